// File: rtl/icache_tag_ctrl_pkg.sv
// Shared types for the icache tag controller: tag memory word layout and FSM states.
// The PF_WAIT state only exists when ICACHE_PREFETCH_EN is defined.
package icache_tag_ctrl_pkg;

  // Default tag width used by the icache tag FIFO.
  localparam int TAG_XLEN = 16;

  // One tag FIFO entry: valid bit above the tag.
  typedef struct packed {
    logic                valid;
    logic [TAG_XLEN-1:0] tag;
  } type_icache_tag_mem_s;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_RF_WAIT = 3'd2,
    ST_TAG_WR  = 3'd3,
    ST_INV     = 3'd4,
`ifdef ICACHE_PREFETCH_EN
    ST_DRAIN   = 3'd5,
    ST_PF_WAIT = 3'd6
`else
    ST_DRAIN   = 3'd5
`endif
  } type_icache_tctl_fsm_e;

endpackage

// File: rtl/icache_tag_ctrl.sv
// Write-side controller for the icache tag FIFO. Serves CPU lookups (hit index or
// refill-then-allocate on a miss), tag invalidation, and drains an outstanding
// refill on flush. All outputs are registered.
// Optional feature: define ICACHE_PREFETCH_EN to fetch the next sequential line
// after a demand fill or a hit whose successor is absent.
module icache_tag_ctrl
  import icache_tag_ctrl_pkg::*;
#(
  parameter int DP    = 4,
  parameter int TAG_W = TAG_XLEN,
  localparam int AW   = $clog2(DP)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             cpu_req,
  input  logic [TAG_W-1:0] cpu_tag,
  output logic             cpu_ack,
  output logic [AW-1:0]    cpu_idx,
  input  logic             inv_req,
  output logic             inv_ack,
  output logic [TAG_W-1:0] tag_cmp_data,
  input  logic [DP-1:0]    tag_hit,
  input  logic [DP-1:0]    tag_next_hit,
  input  logic [AW-1:0]    tag_hindex,
  input  logic [AW-1:0]    tag_wptr,
  input  logic             tag_full,
  output logic             tag_wr,
  output logic             tag_uwr,
  output logic [AW-1:0]    tag_uptr,
  output logic [TAG_W:0]   tag_wdata,
  output logic             refill_req,
  output logic [TAG_W-1:0] refill_tag,
  output logic [AW-1:0]    refill_idx,
  input  logic             refill_done
);

  type_icache_tctl_fsm_e state_q, state_d;
  logic [TAG_W-1:0] cmp_q, cmp_d;
  logic [AW-1:0]    slot_q, slot_d;
  logic             cpu_ack_q, cpu_ack_d;
  logic [AW-1:0]    cpu_idx_q, cpu_idx_d;
  logic             inv_ack_q, inv_ack_d;
  logic             tag_wr_q, tag_wr_d;
  logic             tag_uwr_q, tag_uwr_d;
  logic [AW-1:0]    tag_uptr_q, tag_uptr_d;
  logic [TAG_W:0]   tag_wdata_q, tag_wdata_d;
  logic             refill_req_q, refill_req_d;
  logic [TAG_W-1:0] refill_tag_q, refill_tag_d;
  logic [AW-1:0]    refill_idx_q, refill_idx_d;
`ifdef ICACHE_PREFETCH_EN
  logic             pf_q, pf_d;
  logic             unused_full;
  assign unused_full = tag_full;
`else
  logic             unused_inputs;
  assign unused_inputs = ^{tag_next_hit, tag_full};
`endif

  // A request is still held high during its own ack cycle; do not re-accept it then.
  logic accept_ok;
  assign accept_ok = !cpu_ack_q && !inv_ack_q;

  // Next-state and next-output decode.
  always_comb begin
    state_d      = state_q;
    cmp_d        = cmp_q;
    slot_d       = slot_q;
    cpu_ack_d    = 1'b0;
    cpu_idx_d    = cpu_idx_q;
    inv_ack_d    = 1'b0;
    tag_wr_d     = 1'b0;
    tag_uwr_d    = 1'b0;
    tag_uptr_d   = tag_uptr_q;
    tag_wdata_d  = tag_wdata_q;
    refill_req_d = refill_req_q;
    refill_tag_d = refill_tag_q;
    refill_idx_d = refill_idx_q;
`ifdef ICACHE_PREFETCH_EN
    pf_d         = pf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!flush && accept_ok) begin
          if (inv_req) begin
            cmp_d   = cpu_tag;
            state_d = ST_INV;
          end else if (cpu_req) begin
            cmp_d   = cpu_tag;
            state_d = ST_LOOKUP;
          end
        end
      end
      ST_LOOKUP: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (|tag_hit) begin
          cpu_ack_d = 1'b1;
          cpu_idx_d = tag_hindex;
          state_d   = ST_IDLE;
`ifdef ICACHE_PREFETCH_EN
          if (tag_next_hit == '0) begin
            cmp_d        = cmp_q + 1'b1;
            slot_d       = tag_wptr;
            refill_req_d = 1'b1;
            refill_tag_d = cmp_q + 1'b1;
            refill_idx_d = tag_wptr;
            pf_d         = 1'b1;
            state_d      = ST_PF_WAIT;
          end
`endif
        end else begin
          // Miss: the allocation slot wraps over the oldest line when full.
          slot_d       = tag_wptr;
          refill_req_d = 1'b1;
          refill_tag_d = cmp_q;
          refill_idx_d = tag_wptr;
          state_d      = ST_RF_WAIT;
        end
      end
`ifdef ICACHE_PREFETCH_EN
      ST_RF_WAIT, ST_PF_WAIT: begin
`else
      ST_RF_WAIT: begin
`endif
        if (refill_done) refill_req_d = 1'b0;
        if (flush) state_d = refill_done ? ST_IDLE : ST_DRAIN;
        else if (refill_done) state_d = ST_TAG_WR;
      end
      ST_TAG_WR: begin
        state_d = ST_IDLE;
        if (!flush) begin
          tag_wr_d    = 1'b1;
          tag_wdata_d = {1'b1, cmp_q};
`ifdef ICACHE_PREFETCH_EN
          if (!pf_q) begin
            cpu_ack_d = 1'b1;
            cpu_idx_d = slot_q;
            // The demand line is written this cycle, so the next free slot is wptr+1.
            if (tag_next_hit == '0) begin
              cmp_d        = cmp_q + 1'b1;
              slot_d       = tag_wptr + 1'b1;
              refill_req_d = 1'b1;
              refill_tag_d = cmp_q + 1'b1;
              refill_idx_d = tag_wptr + 1'b1;
              pf_d         = 1'b1;
              state_d      = ST_PF_WAIT;
            end
          end
`else
          cpu_ack_d = 1'b1;
          cpu_idx_d = slot_q;
`endif
        end
      end
      ST_INV: begin
        state_d = ST_IDLE;
        if (!flush) begin
          inv_ack_d = 1'b1;
          if (|tag_hit) begin
            tag_uwr_d   = 1'b1;
            tag_uptr_d  = tag_hindex;
            tag_wdata_d = {1'b0, cmp_q};
          end
        end
      end
      ST_DRAIN: begin
        // The refilled line is discarded; no tag is written.
        if (refill_done) begin
          refill_req_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef ICACHE_PREFETCH_EN
    if (state_d == ST_IDLE) pf_d = 1'b0;
`endif
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cmp_q        <= '0;
      slot_q       <= '0;
      cpu_ack_q    <= 1'b0;
      cpu_idx_q    <= '0;
      inv_ack_q    <= 1'b0;
      tag_wr_q     <= 1'b0;
      tag_uwr_q    <= 1'b0;
      tag_uptr_q   <= '0;
      tag_wdata_q  <= '0;
      refill_req_q <= 1'b0;
      refill_tag_q <= '0;
      refill_idx_q <= '0;
`ifdef ICACHE_PREFETCH_EN
      pf_q         <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cmp_q        <= cmp_d;
      slot_q       <= slot_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_idx_q    <= cpu_idx_d;
      inv_ack_q    <= inv_ack_d;
      tag_wr_q     <= tag_wr_d;
      tag_uwr_q    <= tag_uwr_d;
      tag_uptr_q   <= tag_uptr_d;
      tag_wdata_q  <= tag_wdata_d;
      refill_req_q <= refill_req_d;
      refill_tag_q <= refill_tag_d;
      refill_idx_q <= refill_idx_d;
`ifdef ICACHE_PREFETCH_EN
      pf_q         <= pf_d;
`endif
    end
  end

  assign cpu_ack      = cpu_ack_q;
  assign cpu_idx      = cpu_idx_q;
  assign inv_ack      = inv_ack_q;
  assign tag_cmp_data = cmp_q;
  assign tag_wr       = tag_wr_q;
  assign tag_uwr      = tag_uwr_q;
  assign tag_uptr     = tag_uptr_q;
  assign tag_wdata    = tag_wdata_q;
  assign refill_req   = refill_req_q;
  assign refill_tag   = refill_tag_q;
  assign refill_idx   = refill_idx_q;

endmodule
